// File: rtl/vga_timing_pkg.sv
// ============================================================================
//  Module      : vga_timing_pkg
//  Description : Shared video bus constants, bus struct and timing helpers.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package vga_timing_pkg;

    // Field widths shared by every stage on the video bus
    localparam int VGA_CNT_W   = 11;
    localparam int VGA_RGB_W   = 12;
    localparam int VGA_FRAME_W = 16;

    // SVGA 800x600 @ 60 Hz, 40 MHz pixel clock
    localparam int VGA_H_VISIBLE = 800;
    localparam int VGA_H_FP      = 40;
    localparam int VGA_H_SYNC    = 128;
    localparam int VGA_H_BP      = 88;
    localparam int VGA_V_VISIBLE = 600;
    localparam int VGA_V_FP      = 1;
    localparam int VGA_V_SYNC    = 4;
    localparam int VGA_V_BP      = 23;

    typedef struct packed {
        logic [VGA_CNT_W-1:0] vcount;
        logic                 vsync;
        logic                 vblnk;
        logic [VGA_CNT_W-1:0] hcount;
        logic                 hsync;
        logic                 hblnk;
        logic [VGA_RGB_W-1:0] rgb;
    } vga_bus_t;

    function automatic int vga_total(input int visible, input int fp,
                                     input int sync, input int bp);
        return visible + fp + sync + bp;
    endfunction

endpackage

`default_nettype wire

// File: rtl/vga_timing.sv
// ============================================================================
//  Module      : vga_timing
//  Description : VGA h/v counters with registered, aligned sync/blank flags.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module vga_timing
    import vga_timing_pkg::*;
#(
    parameter int H_VISIBLE = VGA_H_VISIBLE,
    parameter int H_FP      = VGA_H_FP,
    parameter int H_SYNC    = VGA_H_SYNC,
    parameter int H_BP      = VGA_H_BP,
    parameter int V_VISIBLE = VGA_V_VISIBLE,
    parameter int V_FP      = VGA_V_FP,
    parameter int V_SYNC    = VGA_V_SYNC,
    parameter int V_BP      = VGA_V_BP
) (
    input  logic                   pclk,
    input  logic                   rst,
    input  logic                   en,
    output logic [VGA_CNT_W-1:0]   vcount,
    output logic [VGA_CNT_W-1:0]   hcount,
    output logic                   vsync,
    output logic                   vblnk,
    output logic                   hsync,
    output logic                   hblnk,
    output logic                   frame_tick,
    output logic [VGA_FRAME_W-1:0] frame_cnt
);

    localparam logic [VGA_CNT_W-1:0] c_H_LAST =
        VGA_CNT_W'(vga_total(H_VISIBLE, H_FP, H_SYNC, H_BP) - 1);
    localparam logic [VGA_CNT_W-1:0] c_V_LAST =
        VGA_CNT_W'(vga_total(V_VISIBLE, V_FP, V_SYNC, V_BP) - 1);
    localparam logic [VGA_CNT_W-1:0] c_H_BLNK_START = VGA_CNT_W'(H_VISIBLE);
    localparam logic [VGA_CNT_W-1:0] c_H_SYNC_START = VGA_CNT_W'(H_VISIBLE + H_FP);
    localparam logic [VGA_CNT_W-1:0] c_H_SYNC_END   = VGA_CNT_W'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [VGA_CNT_W-1:0] c_V_BLNK_START = VGA_CNT_W'(V_VISIBLE);
    localparam logic [VGA_CNT_W-1:0] c_V_SYNC_START = VGA_CNT_W'(V_VISIBLE + V_FP);
    localparam logic [VGA_CNT_W-1:0] c_V_SYNC_END   = VGA_CNT_W'(V_VISIBLE + V_FP + V_SYNC);

    logic [VGA_CNT_W-1:0]   r_hcount;
    logic [VGA_CNT_W-1:0]   r_vcount;
    logic                   r_hsync;
    logic                   r_hblnk;
    logic                   r_vsync;
    logic                   r_vblnk;
    logic                   r_frame_tick;
    logic [VGA_FRAME_W-1:0] r_frame_cnt;

    logic                   w_h_wrap;
    logic                   w_v_wrap;
    logic [VGA_CNT_W-1:0]   w_h_next;
    logic [VGA_CNT_W-1:0]   w_v_next;

    // Flags are decoded from the next counter values so that, once
    // registered, they describe the same pixel the counters present.
    always_comb begin
        w_h_wrap = (r_hcount == c_H_LAST);
        w_v_wrap = w_h_wrap && (r_vcount == c_V_LAST);
        w_h_next = w_h_wrap ? '0 : r_hcount + 1'b1;
        if (w_h_wrap) begin
            w_v_next = (r_vcount == c_V_LAST) ? '0 : r_vcount + 1'b1;
        end else begin
            w_v_next = r_vcount;
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            r_hcount     <= '0;
            r_vcount     <= '0;
            r_hsync      <= 1'b0;
            r_hblnk      <= 1'b0;
            r_vsync      <= 1'b0;
            r_vblnk      <= 1'b0;
            r_frame_tick <= 1'b0;
            r_frame_cnt  <= '0;
        end else if (en) begin
            r_hcount     <= w_h_next;
            r_vcount     <= w_v_next;
            r_hblnk      <= (w_h_next >= c_H_BLNK_START);
            r_hsync      <= (w_h_next >= c_H_SYNC_START) && (w_h_next < c_H_SYNC_END);
            r_vblnk      <= (w_v_next >= c_V_BLNK_START);
            r_vsync      <= (w_v_next >= c_V_SYNC_START) && (w_v_next < c_V_SYNC_END);
            r_frame_tick <= w_v_wrap;
            if (w_v_wrap) begin
                r_frame_cnt <= r_frame_cnt + 1'b1;
            end
        end else begin
            r_frame_tick <= 1'b0;
        end
    end

    assign hcount     = r_hcount;
    assign vcount     = r_vcount;
    assign hsync      = r_hsync;
    assign hblnk      = r_hblnk;
    assign vsync      = r_vsync;
    assign vblnk      = r_vblnk;
    assign frame_tick = r_frame_tick;
    assign frame_cnt  = r_frame_cnt;

endmodule

`default_nettype wire

// File: tb/tb_vga_timing.sv
// ============================================================================
//  Module      : tb_vga_timing
//  Description : Bench for vga_timing at default and at reduced timings.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_vga_timing;

    // Reduced timing so whole frames fit in a short run: 25 x 16 = 400 cycles
    localparam int SH_V = 16, SH_F = 2, SH_S = 4, SH_B = 3;
    localparam int SV_V = 10, SV_F = 1, SV_S = 2, SV_B = 3;

    logic pclk = 1'b0;
    logic rst  = 1'b1;
    logic en   = 1'b0;

    logic [10:0] d_vcount, d_hcount, s_vcount, s_hcount;
    logic        d_vsync, d_vblnk, d_hsync, d_hblnk, d_tick;
    logic        s_vsync, s_vblnk, s_hsync, s_hblnk, s_tick;
    logic [15:0] d_fcnt, s_fcnt;

    always #5 pclk = ~pclk;

    vga_timing dut_def (
        .pclk(pclk), .rst(rst), .en(en),
        .vcount(d_vcount), .hcount(d_hcount),
        .vsync(d_vsync), .vblnk(d_vblnk), .hsync(d_hsync), .hblnk(d_hblnk),
        .frame_tick(d_tick), .frame_cnt(d_fcnt)
    );

    vga_timing #(
        .H_VISIBLE(SH_V), .H_FP(SH_F), .H_SYNC(SH_S), .H_BP(SH_B),
        .V_VISIBLE(SV_V), .V_FP(SV_F), .V_SYNC(SV_S), .V_BP(SV_B)
    ) dut_sm (
        .pclk(pclk), .rst(rst), .en(en),
        .vcount(s_vcount), .hcount(s_hcount),
        .vsync(s_vsync), .vblnk(s_vblnk), .hsync(s_hsync), .hblnk(s_hblnk),
        .frame_tick(s_tick), .frame_cnt(s_fcnt)
    );

    int total = 0;
    int bad   = 0;

    // Reference: number of enabled cycles since reset, plus whether the
    // last edge advanced. Every output follows from these by arithmetic.
    longint pos = 0;
    bit     adv = 1'b0;
    int     s_ticks = 0;
    int     s_vsyncs = 0;

    function automatic logic [42:0] model(input longint p, input bit a,
                                          input int hv, input int hf, input int hs, input int hb,
                                          input int vv, input int vf, input int vs, input int vb);
        longint ht, vt, ft, h, v, f;
        logic   e_hb, e_hs, e_vb, e_vs, e_tk;
        ht   = hv + hf + hs + hb;
        vt   = vv + vf + vs + vb;
        ft   = ht * vt;
        h    = p % ht;
        v    = (p / ht) % vt;
        f    = (p / ft) % 65536;
        e_hb = (h >= hv);
        e_hs = (h >= hv + hf) && (h < hv + hf + hs);
        e_vb = (v >= vv);
        e_vs = (v >= vv + vf) && (v < vv + vf + vs);
        e_tk = a && (p > 0) && ((p % ft) == 0);
        return {16'(f), e_tk, e_vs, e_vb, e_hs, e_hb, 11'(v), 11'(h)};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic e);
        rst = r;
        en  = e;
        @(posedge pclk);
        #1;
        if (r) begin
            pos = 0;
            adv = 1'b0;
        end else if (e) begin
            pos++;
            adv = 1'b1;
        end else begin
            adv = 1'b0;
        end
        check("def_model",
              64'({d_fcnt, d_tick, d_vsync, d_vblnk, d_hsync, d_hblnk, d_vcount, d_hcount}),
              64'(model(pos, adv, 800, 40, 128, 88, 600, 1, 4, 23)));
        check("sm_model",
              64'({s_fcnt, s_tick, s_vsync, s_vblnk, s_hsync, s_hblnk, s_vcount, s_hcount}),
              64'(model(pos, adv, SH_V, SH_F, SH_S, SH_B, SV_V, SV_F, SV_S, SV_B)));
        if (s_tick)  s_ticks++;
        if (s_vsync) s_vsyncs++;
    endtask

    typedef struct {
        bit rst;
        bit en;
        int n;
        int h;
        int v;
        bit hs;
        bit hb;
    } vec_t;

    vec_t tbl[12];

    initial begin
        tbl[0]  = '{1, 1,    1,   0, 0, 0, 0};
        tbl[1]  = '{0, 1,  839, 839, 0, 0, 1};
        tbl[2]  = '{0, 1,    1, 840, 0, 1, 1};
        tbl[3]  = '{0, 1,  127, 967, 0, 1, 1};
        tbl[4]  = '{0, 1,    1, 968, 0, 0, 1};
        tbl[5]  = '{0, 1,   87, 1055, 0, 0, 1};
        tbl[6]  = '{0, 1,    1,   0, 1, 0, 0};
        tbl[7]  = '{0, 0,    5,   0, 1, 0, 0};
        tbl[8]  = '{0, 1,  400, 400, 1, 0, 0};
        tbl[9]  = '{0, 0,   50, 400, 1, 0, 0};
        tbl[10] = '{0, 1,    1, 401, 1, 0, 0};
        tbl[11] = '{0, 1, 1055, 400, 2, 0, 0};

        step(1'b1, 1'b0);
        check("reset_state",
              64'({d_fcnt, d_tick, d_vsync, d_vblnk, d_hsync, d_hblnk, d_vcount, d_hcount}),
              64'd0);

        // Line-level landmarks on the default timing
        for (int i = 0; i < 12; i++) begin
            for (int k = 0; k < tbl[i].n; k++) step(tbl[i].rst, tbl[i].en);
            check($sformatf("vec%0d", i),
                  64'({d_hcount, d_vcount, d_hsync, d_hblnk, d_vsync, d_vblnk}),
                  64'({11'(tbl[i].h), 11'(tbl[i].v), tbl[i].hs, tbl[i].hb, 2'b00}));
        end

        // Three whole frames on the reduced timing
        step(1'b1, 1'b0);
        s_ticks  = 0;
        s_vsyncs = 0;
        for (int k = 0; k < 3 * 400; k++) step(1'b0, 1'b1);
        check("three_frame_ticks", 64'(s_ticks), 64'd3);
        check("three_frame_cnt", 64'(s_fcnt), 64'd3);
        check("vsync_cycles", 64'(s_vsyncs), 64'(3 * SV_S * 25));

        // Reset mid-frame at (20,12) of the reduced timing
        step(1'b1, 1'b0);
        for (int k = 0; k < 12 * 25 + 20; k++) step(1'b0, 1'b1);
        check("midframe_pos", 64'({s_vcount, s_hcount}), 64'({11'd12, 11'd20}));
        step(1'b1, 1'b1);
        check("midframe_rst",
              64'({s_fcnt, s_tick, s_vsync, s_vblnk, s_hsync, s_hblnk, s_vcount, s_hcount}),
              64'd0);
        step(1'b0, 1'b1);
        check("restart", 64'({s_vcount, s_hcount, s_tick}), 64'({11'd0, 11'd1, 1'b0}));

        // Random enable with occasional resets
        for (int k = 0; k < 20000; k++) begin
            step(($urandom_range(999) == 0), ($urandom_range(3) != 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/vga_timing.md
VGA_TIMING -- requirements
Module: vga_timing

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high, with ports pclk and rst.
REQ-002 Parameter H_VISIBLE, default 800, SHALL set active pixels per line.
REQ-003 Parameter H_FP, default 40, SHALL set the horizontal front porch in pixels.
REQ-004 Parameter H_SYNC, default 128, SHALL set the hsync width in pixels.
REQ-005 Parameter H_BP, default 88, SHALL set the horizontal back porch; H_TOTAL = sum of the four = 1056.
REQ-006 Parameter V_VISIBLE, default 600, SHALL set active lines per frame.
REQ-007 Parameter V_FP, default 1, SHALL set the vertical front porch in lines.
REQ-008 Parameter V_SYNC, default 4, SHALL set the vsync width in lines.
REQ-009 Parameter V_BP, default 23, SHALL set the vertical back porch; V_TOTAL = sum = 628.
REQ-010 Port pclk, input, 1 bit, SHALL be the pixel clock (40 MHz for the defaults).
REQ-011 Port rst, input, 1 bit, SHALL be the synchronous active-high reset.
REQ-012 Port en, input, 1 bit, SHALL be a count enable; low freezes all state.
REQ-013 Port vcount, output, 11 bits, SHALL be the current line index.
REQ-014 Port hcount, output, 11 bits, SHALL be the current pixel index.
REQ-015 Port vsync, output, 1 bit, SHALL be vertical sync, active high.
REQ-016 Port vblnk, output, 1 bit, SHALL be vertical blanking, active high.
REQ-017 Port hsync, output, 1 bit, SHALL be horizontal sync, active high.
REQ-018 Port hblnk, output, 1 bit, SHALL be horizontal blanking, active high.
REQ-019 Port frame_tick, output, 1 bit, SHALL be a one-cycle pulse at frame start.
REQ-020 Port frame_cnt, output, 16 bits, SHALL be the number of completed frames.

Function
REQ-021 hcount SHALL increment by 1 per pclk while en=1 and wrap from H_TOTAL-1 (1055) to 0.
REQ-022 vcount SHALL increment by 1 only in the cycle hcount wraps, and SHALL wrap from V_TOTAL-1 (627) to 0.
REQ-023 hblnk SHALL be 1 exactly when hcount >= H_VISIBLE (800..1055).
REQ-024 hsync SHALL be 1 exactly when H_VISIBLE+H_FP <= hcount < H_VISIBLE+H_FP+H_SYNC (840..967).
REQ-025 vblnk SHALL be 1 exactly when vcount >= V_VISIBLE (600..627).
REQ-026 vsync SHALL be 1 exactly when V_VISIBLE+V_FP <= vcount < V_VISIBLE+V_FP+V_SYNC (601..604).
REQ-027 All outputs SHALL be registered and mutually aligned: sync/blank flags describe the hcount/vcount value presented in the same cycle, with no skew between fields.
REQ-028 frame_tick SHALL be 1 for exactly one cycle, the cycle in which hcount=0 and vcount=0 following a wrap, and SHALL NOT assert after reset alone.
REQ-029 frame_cnt SHALL increment by 1 at each frame_tick and wrap from 65535 to 0.
REQ-030 When en=0, counters, flags and frame_cnt SHALL hold, and frame_tick SHALL be 0.
REQ-031 Counter arithmetic SHALL be 11-bit unsigned; the boundary comparisons SHALL be derived from the parameters, not hard-coded literals.

Reset
REQ-032 When rst=1 at a pclk edge, hcount, vcount and frame_cnt SHALL be 0, and hsync, vsync, hblnk, vblnk and frame_tick SHALL be 0.
REQ-033 rst SHALL take priority over en, and reset mid-frame SHALL restart at pixel (0,0) on the next enabled cycle after release.

Structure
REQ-034 The timing defaults and the video bus field widths (11-bit counts, 12-bit RGB) SHALL live in the shared video bus header, so downstream draw stages use identical constants.
REQ-035 The outputs SHALL be packed into the shared video bus format by the instantiating top, with rgb driven 0 by this stage; this block feeds the background draw stage directly.
REQ-036 The block SHALL be a single module with no sub-module; the h and v counters are inline.

Verification
REQ-037 Release rst, en=1, run 1056 cycles -> hcount sequences 0..1055 then 0, and vcount goes 0 to 1 on the wrap cycle.
REQ-038 Sample at hcount=839/840/967/968 -> hsync=0/1/1/0, with hblnk=1 at all four.
REQ-039 Run a full frame -> vsync high for exactly 4x1056 = 4224 cycles starting at vcount=601, and vblnk high for lines 600..627.
REQ-040 Run 3 frames (3x663168 cycles) -> exactly 3 frame_tick pulses, each one cycle wide, and frame_cnt=3.
REQ-041 Hold en=0 for 50 cycles mid-line at hcount=400 -> all outputs frozen, and counting resumes at 401.
REQ-042 Assert rst for 1 cycle at (700,300) -> the next cycle shows all outputs 0, frame_cnt=0 and no frame_tick.
